rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Round-robin arbiter that shares one single-owner resource (e.g. a shared gate-level datapath or bus) among N requesters. It issues one-hot registered grants and holds each grant until the owner signals DONE, drops its request, or exceeds a hold-time limit. It sits between the requester blocks and the shared resource, and is synthesized onto the team's standard-cell library.

## Interface
- N, default 4: number of requesters, 2..8.
- TIMEOUT, default 15: maximum GRANT cycles per ownership, at least 2.
- IDW, derived, clog2(N): width of GNT_ID.
- CW, derived, clog2(TIMEOUT+1): width of the hold counter.

Ports:
- C  in  1  clock; all state changes on the rising edge.
- RN  in  1  reset, asynchronous, active-low.
- REQ  in  N  request per requester; level-sensitive, held until granted.
- DONE  in  1  current owner finished its transaction; ignored outside GRANT.
- GNT  out  N  one-hot grant, registered; all zeros when nobody owns the resource.
- GNT_ID  out  IDW  index of the current or last owner, registered.
- BUSY  out  1  high while in GRANT.
- TOUT  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner holds the resource.
  - RELEASE: one dead cycle with GNT = 0.
- Internal registers:
  - PTR (IDW bits): round-robin priority pointer.
  - CNT (CW bits): hold counter.
  - OWN: current owner index.
- Pick function:
  - Returns the first index i with REQ[i] = 1, searching PTR, PTR+1, … mod N.
  - Only valid when REQ ≠ 0.
- IDLE:
  - If REQ ≠ 0, go to GRANT. GNT ← onehot(pick), GNT_ID ← pick, CNT ← 0.
  - Otherwise stay in IDLE.
- GRANT (each cycle, CNT increments, saturating at TIMEOUT). The first matching exit below applies:
  1. DONE = 1 → RELEASE, TOUT = 0.
  2. REQ[OWN] = 0 → RELEASE, TOUT = 0.
  3. CNT = TIMEOUT−1 → RELEASE, TOUT ← 1.
  4. Otherwise stay in GRANT with GNT unchanged.
- On every exit from GRANT: PTR ← (OWN+1) mod N, and GNT ← 0.
- RELEASE:
  - TOUT returns to 0 at the next edge.
  - Arbitrates with the updated PTR: if REQ ≠ 0, go to GRANT with the new pick; otherwise go to IDLE.
- Boundary rules:
  - DONE and timeout in the same cycle: DONE wins, no TOUT.
  - PTR wraps N−1 → 0.
  - A requester that was just served has lowest priority in the next pick. With all REQ high, grants rotate 0,1,…,N−1,0.
  - REQ changes during RELEASE are sampled by the RELEASE pick; no glitch grant.
  - At most one GNT bit is ever high. GNT is never high in IDLE or RELEASE.
- Reset (RN = 0, any state, including mid-grant), asynchronous:
  - GNT = 0, GNT_ID = 0, BUSY = 0, TOUT = 0.
  - PTR = 0, CNT = 0, state IDLE.
  - First possible grant is at the first rising edge after RN rises.

## Timing
- Grant latency: REQ high before edge k in IDLE → GNT valid after edge k (one cycle).
- Turnaround: DONE sampled at edge m → GNT low after m → next GNT after m+1. Exactly one dead cycle between owners.
- Maximum hold: GNT is high for at most TIMEOUT cycles. TOUT is high during the RELEASE cycle that follows a timeout.
- All outputs come straight from flops; there are no combinational paths from input to output.
- Inputs are synchronous to C and must meet cell-library flop setup/hold at the edge.

## Structure
- Shared package rr_pkg:
  - State encoding constants ST_IDLE = 2'b00, ST_GRANT = 2'b01, ST_RELEASE = 2'b10.
  - The clog2 helper.
- Sub-module rr_pick:
  - Purely combinational rotating-priority selector.
  - Inputs: REQ, PTR. Outputs: index, valid.
  - Instantiated once and shared by the IDLE and RELEASE arbitration.
- Top level holds the FSM, PTR, CNT, OWN and output registers.

## Test plan
1. Reset: RN = 0 with REQ = 4'b1111 → all outputs 0. Release RN → GNT = 4'b0001 after the first edge, BUSY = 1.
2. Rotation: REQ = 4'b1111 with DONE pulsed one cycle after each grant → GNT sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
3. Timeout: REQ = 4'b0100 held, DONE = 0 → GNT = 0100 for exactly 15 cycles, then TOUT = 1 for one cycle with GNT = 0, then GNT = 0100 again.
4. DONE and timeout together: DONE asserted on the 15th GRANT cycle → TOUT stays 0, and PTR advances to 3.
5. Request drop plus pointer wrap: owner 3 drops REQ, REQ = 4'b0011 → one dead cycle, then GNT = 0001.
6. Reset mid-grant: RN pulsed low while GNT = 0010 → GNT = 0 immediately (asynchronous). After release, the next grant goes to the lowest active REQ index from PTR = 0.

Source files
------------

// File: rtl/rr_pkg.sv
// rr_arbiter shared definitions
// FSM state encoding and width helper
package rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector
// First set request at or after ptr, mod N
module rr_pick
  import rr_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [IDW-1:0] o_idx,
  output logic           o_valid
);

  // highest offset first so the nearest request wins last
  always_comb begin
    int j;
    logic [IDW-1:0] w_j;
    j       = 0;
    w_j     = '0;
    o_idx   = '0;
    o_valid = |i_req;
    for (int k = N - 1; k >= 0; k--) begin
      j   = (int'(i_ptr) + k) % N;
      w_j = IDW'(j);
      if (i_req[w_j]) o_idx = w_j;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, one-hot registered grant
// Hold ends on DONE, request drop or hold limit
module rr_arbiter
  import rr_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 15,
  localparam int IDW     = clog2(N),
  localparam int CW      = clog2(TIMEOUT + 1)
) (
  input  logic           C,
  input  logic           RN,
  input  logic [N-1:0]   REQ,
  input  logic           DONE,
  output logic [N-1:0]   GNT,
  output logic [IDW-1:0] GNT_ID,
  output logic           BUSY,
  output logic           TOUT
);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [IDW-1:0] r_own;
  logic [N-1:0]   r_gnt;
  logic           r_busy;
  logic           r_tout;

  logic [IDW-1:0] w_idx;
  logic           w_valid;
  logic [IDW-1:0] w_nxt;
  logic           w_hit;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // pointer after the owner, wrapping at N-1
  assign w_nxt = (r_own == IDW'(N - 1))
               ? '0 : r_own + 1'b1;

  // hold limit reached on this grant cycle
  assign w_hit = (r_cnt == CW'(TIMEOUT - 1));

  // arbitration FSM with registered outputs
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_own   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_RELEASE: begin
          r_tout <= 1'b0;
          if (w_valid) begin
            r_state <= ST_GRANT;
            r_own   <= w_idx;
            r_gnt   <= N'(1) << w_idx;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (r_cnt != CW'(TIMEOUT))
            r_cnt <= r_cnt + 1'b1;
          if (DONE || !REQ[r_own] || w_hit) begin
            r_state <= ST_RELEASE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_nxt;
            r_tout  <= !DONE && REQ[r_own];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_tout  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign GNT_ID = r_own;
  assign BUSY   = r_busy;
  assign TOUT   = r_tout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter
// Hand-computed vectors, N=4, TIMEOUT=15
module tb_rr_arbiter;

  logic       C;
  logic       RN;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       TOUT;

  int n_chk;
  int n_err;

  rr_arbiter #(
    .N       (4),
    .TIMEOUT (15)
  ) dut (
    .C      (C),
    .RN     (RN),
    .REQ    (REQ),
    .DONE   (DONE),
    .GNT    (GNT),
    .GNT_ID (GNT_ID),
    .BUSY   (BUSY),
    .TOUT   (TOUT)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    RN    = 1'b0;
    REQ   = 4'b1111;
    DONE  = 1'b0;

    // reset state
    #2;
    chk("rst_gnt", 8'(GNT), 8'h0);
    chk("rst_id", 8'(GNT_ID), 8'h0);
    chk("rst_busy", 8'(BUSY), 8'h0);
    chk("rst_tout", 8'(TOUT), 8'h0);
    RN = 1'b1;
    tick();
    chk("first_gnt", 8'(GNT), 8'h1);
    chk("first_busy", 8'(BUSY), 8'h1);

    // rotation with DONE one cycle after each grant
    for (int k = 0; k < 4; k++) begin
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      chk("rot_dead", 8'(GNT), 8'h0);
      chk("rot_dbusy", 8'(BUSY), 8'h0);
      tick();
      chk("rot_gnt", 8'(GNT),
          8'(4'b0001 << ((k + 1) % 4)));
      chk("rot_id", 8'(GNT_ID), 8'((k + 1) % 4));
    end

    // owner 0 drops, only 2 requests
    REQ = 4'b0100;
    tick();
    chk("drop0_dead", 8'(GNT), 8'h0);
    tick();
    chk("to_gnt1", 8'(GNT), 8'h4);
    chk("to_id", 8'(GNT_ID), 8'h2);
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk("to_hold", 8'(GNT), 8'h4);
      chk("to_tlow", 8'(TOUT), 8'h0);
    end
    tick();
    chk("to_gnt0", 8'(GNT), 8'h0);
    chk("to_pulse", 8'(TOUT), 8'h1);
    chk("to_busy", 8'(BUSY), 8'h0);
    tick();
    chk("to_end", 8'(TOUT), 8'h0);
    chk("to_regnt", 8'(GNT), 8'h4);

    // DONE on the 15th grant cycle beats timeout
    for (int c = 2; c <= 15; c++) begin
      tick();
      chk("dt_hold", 8'(GNT), 8'h4);
    end
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk("dt_gnt0", 8'(GNT), 8'h0);
    chk("dt_notout", 8'(TOUT), 8'h0);
    REQ = 4'b1111;
    tick();
    chk("dt_ptr3", 8'(GNT), 8'h8);
    chk("dt_id3", 8'(GNT_ID), 8'h3);

    // owner 3 drops, pointer wraps to 0
    REQ = 4'b0011;
    tick();
    chk("wr_dead", 8'(GNT), 8'h0);
    chk("wr_tout", 8'(TOUT), 8'h0);
    tick();
    chk("wr_gnt", 8'(GNT), 8'h1);
    chk("wr_id", 8'(GNT_ID), 8'h0);

    // reset while owner 1 holds
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    tick();
    chk("mr_pre", 8'(GNT), 8'h2);
    #2;
    RN = 1'b0;
    #1;
    chk("mr_gnt", 8'(GNT), 8'h0);
    chk("mr_busy", 8'(BUSY), 8'h0);
    chk("mr_id", 8'(GNT_ID), 8'h0);
    REQ = 4'b0101;
    #1;
    RN = 1'b1;
    tick();
    chk("mr_after", 8'(GNT), 8'h1);
    chk("mr_aid", 8'(GNT_ID), 8'h0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
